// File: rtl/dvp_cap_pkg.sv
// Shared types and widths for the DVP capture path: FSM states, pixel/word geometry, word counter width.
package dvp_cap_pkg;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 64;
  localparam int LANES  = 4;
  localparam int WCNT_W = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_PAD,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/dvp_pix_packer.sv
// Assembles 16-bit pixels into 64-bit words, lane 0 in the low bits; word_vld is combinational with the 4th pixel.
// With no pixel pending completion, word_dat is the partial word zero-filled above its last lane; flush drops it.
module dvp_pix_packer
  import dvp_cap_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix_dat,
  input  logic              flush,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [1:0]                   lane_cnt;
  logic [PIX_W*(LANES-1)-1:0]   lanes;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lane_cnt <= 2'd0;
      lanes    <= '0;
    end else if (flush) begin
      lane_cnt <= 2'd0;
    end else if (pix_vld) begin
      case (lane_cnt)
        2'd0:    lanes[15:0]  <= pix_dat;
        2'd1:    lanes[31:16] <= pix_dat;
        2'd2:    lanes[47:32] <= pix_dat;
        default: ;
      endcase
      lane_cnt <= lane_cnt + 2'd1;
    end
  end

  always_comb begin
    word_vld = pix_vld & (lane_cnt == 2'd3);
    word_dat = '0;
    // Stale upper lanes from the previous word are masked off by lane_cnt.
    case (lane_cnt)
      2'd1:    word_dat = {48'd0, lanes[15:0]};
      2'd2:    word_dat = {32'd0, lanes[31:0]};
      2'd3:    word_dat = word_vld ? {pix_dat, lanes} : {16'd0, lanes};
      default: word_dat = '0;
    endcase
  end

endmodule

// File: rtl/dvp_frame_writer_ctrl.sv
// Packs DVP pixels into FIFO words, issues one WR_START per frame and always delivers FRAME_BYTES/8 words (zero padded).
// Word write lands the cycle after its 4th pixel; FIFO_FULL then discards it; padding stalls on FIFO_FULL. Option: DVP_TEST_PATTERN_EN.
module dvp_frame_writer_ctrl
  import dvp_cap_pkg::*;
#(
  parameter logic [31:0] FRAME_BYTES = 32'd614400,
  parameter int unsigned NUM_BUFS    = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0020_0000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              ENABLE,
  input  logic              TEST_MODE,
  input  logic              VSYNC_IN,
  input  logic              PIX_VALID,
  input  logic [PIX_W-1:0]  PIX_DATA,
  input  logic              FIFO_FULL,
  output logic              FIFO_WE,
  output logic [WORD_W-1:0] FIFO_DATA,
  input  logic              WR_READY,
  input  logic              WR_DONE,
  output logic              WR_START,
  output logic [31:0]       WR_ADRS,
  output logic [31:0]       WR_LEN,
  output logic              FRAME_DONE,
  output logic [1:0]        FRAME_IDX,
  output logic              OVERFLOW,
  output logic              SHORT_FRAME,
  output logic [15:0]       DROP_CNT,
  output logic              BUSY
);

  localparam logic [WCNT_W-1:0] WORDS    = FRAME_BYTES[31:3];
  localparam logic [1:0]        LAST_IDX = 2'(NUM_BUFS - 1);

  state_t              state_q, state_d;
  logic                vs_s, vs_q, vs_edge;
  logic [WCNT_W-1:0]   word_cnt;
  logic [1:0]          wr_idx;
  logic                at_target, start, drop, short_hit, done, cap_en, pad_wr, word_wr;
  logic                pk_pix_vld, pk_flush, pk_vld;
  logic [PIX_W-1:0]    pix_sel;
  logic [WORD_W-1:0]   pk_dat;

  assign vs_edge    = vs_s & ~vs_q;
  assign at_target  = (word_cnt == WORDS);
  assign pk_pix_vld = cap_en & PIX_VALID;
  assign pk_flush   = start | pad_wr;
  assign word_wr    = pk_vld & ~FIFO_FULL;
  assign WR_LEN     = FRAME_BYTES;

`ifdef DVP_TEST_PATTERN_EN
  logic [PIX_W-1:0] pat_cnt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)        pat_cnt <= '0;
    else if (start)      pat_cnt <= '0;
    else if (pk_pix_vld) pat_cnt <= pat_cnt + 16'd1;
  end

  assign pix_sel = TEST_MODE ? pat_cnt : PIX_DATA;
`else
  logic unused_test_mode;
  assign unused_test_mode = TEST_MODE;
  assign pix_sel          = PIX_DATA;
`endif

  dvp_pix_packer u_packer (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .pix_vld  (pk_pix_vld),
    .pix_dat  (pix_sel),
    .flush    (pk_flush),
    .word_vld (pk_vld),
    .word_dat (pk_dat)
  );

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    drop      = 1'b0;
    short_hit = 1'b0;
    done      = 1'b0;
    cap_en    = 1'b0;
    pad_wr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (vs_edge) begin
          if (WR_READY) begin
            start   = 1'b1;
            state_d = ST_CAPTURE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        // Any sync seen here is consumed, so that frame never gets a start.
        drop = vs_edge;
        if (at_target) begin
          state_d = ST_WAIT_DONE;
        end else if (vs_edge) begin
          short_hit = 1'b1;
          state_d   = ST_PAD;
        end else if (!ENABLE) begin
          state_d = ST_PAD;
        end else begin
          cap_en = 1'b1;
        end
      end
      ST_PAD: begin
        drop = vs_edge;
        if (at_target) state_d = ST_WAIT_DONE;
        else           pad_wr  = ~FIFO_FULL;
      end
      ST_WAIT_DONE: begin
        drop = vs_edge;
        if (WR_DONE) begin
          done    = 1'b1;
          state_d = ENABLE ? ST_WAIT_VS : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      vs_s        <= 1'b0;
      vs_q        <= 1'b0;
      word_cnt    <= '0;
      wr_idx      <= 2'd0;
      FIFO_WE     <= 1'b0;
      FIFO_DATA   <= '0;
      WR_START    <= 1'b0;
      WR_ADRS     <= BASE_ADDR;
      FRAME_DONE  <= 1'b0;
      FRAME_IDX   <= 2'd0;
      OVERFLOW    <= 1'b0;
      SHORT_FRAME <= 1'b0;
      DROP_CNT    <= 16'd0;
      BUSY        <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Pin sample stage ahead of the edge detector: start lands two cycles after the pin rises.
      vs_s       <= VSYNC_IN;
      vs_q       <= vs_s;
      WR_START   <= start;
      FIFO_WE    <= word_wr | pad_wr;
      FRAME_DONE <= done;
      BUSY       <= (state_d != ST_IDLE);
      if (word_wr | pad_wr) FIFO_DATA <= pk_dat;
      if (start) begin
        WR_ADRS  <= BASE_ADDR + ({30'd0, wr_idx} * BUF_STRIDE);
        word_cnt <= '0;
      end else if (word_wr | pad_wr) begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end
      if (pk_vld & FIFO_FULL) OVERFLOW <= 1'b1;
      if (short_hit) SHORT_FRAME <= 1'b1;
      if (drop && (DROP_CNT != 16'hFFFF)) DROP_CNT <= DROP_CNT + 16'd1;
      if (done) begin
        FRAME_IDX <= wr_idx;
        wr_idx    <= (wr_idx == LAST_IDX) ? 2'd0 : wr_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_writer_ctrl.sv
// Directed frame sequence with random pixels/gaps/FIFO_FULL, checked against a word-list model of each frame.
module tb_dvp_frame_writer_ctrl;

  localparam logic [31:0] FB     = 32'd64;
  localparam int          W      = 8;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0020_0000;

  logic        ACLK = 1'b0;
  logic        ARESETN, ENABLE, TEST_MODE, VSYNC_IN, PIX_VALID, FIFO_FULL, WR_READY, WR_DONE;
  logic [15:0] PIX_DATA;
  logic        FIFO_WE, WR_START, FRAME_DONE, OVERFLOW, SHORT_FRAME, BUSY;
  logic [63:0] FIFO_DATA;
  logic [31:0] WR_ADRS, WR_LEN;
  logic [1:0]  FRAME_IDX;
  logic [15:0] DROP_CNT;

  always #5 ACLK = ~ACLK;

  dvp_frame_writer_ctrl #(
    .FRAME_BYTES (FB),
    .NUM_BUFS    (3),
    .BASE_ADDR   (BASE),
    .BUF_STRIDE  (STRIDE)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ENABLE      (ENABLE),
    .TEST_MODE   (TEST_MODE),
    .VSYNC_IN    (VSYNC_IN),
    .PIX_VALID   (PIX_VALID),
    .PIX_DATA    (PIX_DATA),
    .FIFO_FULL   (FIFO_FULL),
    .FIFO_WE     (FIFO_WE),
    .FIFO_DATA   (FIFO_DATA),
    .WR_READY    (WR_READY),
    .WR_DONE     (WR_DONE),
    .WR_START    (WR_START),
    .WR_ADRS     (WR_ADRS),
    .WR_LEN      (WR_LEN),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_IDX   (FRAME_IDX),
    .OVERFLOW    (OVERFLOW),
    .SHORT_FRAME (SHORT_FRAME),
    .DROP_CNT    (DROP_CNT),
    .BUSY        (BUSY)
  );

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          start_cnt   = 0;
  logic [31:0] last_adrs   = '0;
  int          checks      = 0;
  int          errors      = 0;
  int          frames_done = 0;
  int          exp_drop    = 0;
  int          sc0;

  // Recorder only: FIFO writes and start pulses, sampled on the falling edge.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (FIFO_WE) got_q.push_back(FIFO_DATA);
      if (WR_START) begin
        start_cnt++;
        last_adrs = WR_ADRS;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic vsync_pulse(input bit exp_start);
    logic [3:0] s;
    VSYNC_IN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      s[k] = WR_START;
    end
    @(posedge ACLK);
    #1;
    VSYNC_IN = 1'b0;
    cyc(3);
    chk("wr_start_t0", 64'(s[0]), 64'd0);
    chk("wr_start_t1", 64'(s[1]), 64'd0);
    chk("wr_start_t2", 64'(s[2]), 64'(exp_start));
    chk("wr_start_t3", 64'(s[3]), 64'd0);
  endtask

  // mode 0: FIFO never full; 1: full on the 4th pixel of word slots 2..5; 2: random full.
  task automatic send_pix(input int n, input int mode, output logic [63:0] part, output int plane);
    logic [63:0] acc;
    logic [15:0] px;
    logic        full;
    int          lane;
    int          slot;
    acc  = '0;
    lane = 0;
    slot = 0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, 2);
      if (g > 0) cyc(g);
      px = (TEST_MODE === 1'b1) ? 16'(i) : 16'($urandom);
      case (mode)
        1:       full = (lane == 3) && (slot >= 2) && (slot <= 5);
        2:       full = ($urandom_range(0, 9) < 3);
        default: full = 1'b0;
      endcase
      PIX_VALID = 1'b1;
      PIX_DATA  = px;
      FIFO_FULL = full;
      cyc(1);
      PIX_VALID = 1'b0;
      FIFO_FULL = 1'b0;
      acc[lane*16 +: 16] = px;
      if (lane == 3) begin
        if (!full) exp_q.push_back(acc);
        acc  = '0;
        lane = 0;
        slot++;
      end else begin
        lane++;
      end
    end
    part  = acc;
    plane = lane;
  endtask

  task automatic run_frame(input int n, input int mode, input bit short_end, input bit vs_in_wait);
    int          sc;
    int          plane;
    logic [31:0] ea;
    logic [63:0] part;
    exp_q.delete();
    got_q.delete();
    sc = start_cnt;
    ea = BASE + 32'(frames_done % 3) * STRIDE;
    vsync_pulse(1'b1);
    chk("start_cnt", 64'(start_cnt), 64'(sc + 1));
    chk("wr_adrs", 64'(last_adrs), 64'(ea));
    send_pix(n, mode, part, plane);
    if (short_end) begin
      vsync_pulse(1'b0);
      exp_drop++;
      if (plane != 0) exp_q.push_back(part);
      while (exp_q.size() < W) exp_q.push_back(64'd0);
    end
    for (int k = 0; k < 2000 && got_q.size() < W; k++) begin
      FIFO_FULL = (mode == 2) && ($urandom_range(0, 1) == 1);
      cyc(1);
    end
    FIFO_FULL = 1'b0;
    cyc(4);
    chk("word_count", 64'(got_q.size()), 64'(W));
    for (int k = 0; k < W && k < got_q.size(); k++) chk("word", got_q[k], exp_q[k]);
    if (vs_in_wait) begin
      vsync_pulse(1'b0);
      exp_drop++;
    end
    chk("busy_wait_done", 64'(BUSY), 64'd1);
    chk("adrs_hold", 64'(WR_ADRS), 64'(ea));
    WR_DONE = 1'b1;
    cyc(1);
    WR_DONE = 1'b0;
    @(negedge ACLK);
    chk("frame_done", 64'(FRAME_DONE), 64'd1);
    chk("frame_idx", 64'(FRAME_IDX), 64'(frames_done % 3));
    @(negedge ACLK);
    chk("frame_done_pulse", 64'(FRAME_DONE), 64'd0);
    @(posedge ACLK);
    #1;
    frames_done++;
    chk("drop_cnt", 64'(DROP_CNT), 64'(exp_drop));
  endtask

  initial begin
    ARESETN   = 1'b0;
    ENABLE    = 1'b0;
    TEST_MODE = 1'b0;
    VSYNC_IN  = 1'b0;
    PIX_VALID = 1'b0;
    PIX_DATA  = 16'd0;
    FIFO_FULL = 1'b0;
    WR_READY  = 1'b1;
    WR_DONE   = 1'b0;
    cyc(3);
    @(negedge ACLK);
    chk("rst_fifo_we", 64'(FIFO_WE), 64'd0);
    chk("rst_fifo_data", FIFO_DATA, 64'd0);
    chk("rst_wr_start", 64'(WR_START), 64'd0);
    chk("rst_wr_adrs", 64'(WR_ADRS), 64'(BASE));
    chk("rst_wr_len", 64'(WR_LEN), 64'(FB));
    chk("rst_frame_done", 64'(FRAME_DONE), 64'd0);
    chk("rst_frame_idx", 64'(FRAME_IDX), 64'd0);
    chk("rst_overflow", 64'(OVERFLOW), 64'd0);
    chk("rst_short", 64'(SHORT_FRAME), 64'd0);
    chk("rst_drop", 64'(DROP_CNT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    cyc(2);
    chk("busy_idle", 64'(BUSY), 64'd0);
    ENABLE = 1'b1;
    cyc(2);
    chk("busy_enabled", 64'(BUSY), 64'd1);

    // Four full frames: buffer rotation 0,1,2,0.
    for (int f = 0; f < 4; f++) run_frame(32, 0, 1'b0, 1'b0);
    chk("no_overflow", 64'(OVERFLOW), 64'd0);
    chk("no_short", 64'(SHORT_FRAME), 64'd0);

    // Short frame ending mid-word: partial word zero-filled, then zero words.
    run_frame(10, 0, 1'b1, 1'b0);
    chk("short_set", 64'(SHORT_FRAME), 64'd1);
    chk("overflow_still_clear", 64'(OVERFLOW), 64'd0);

    // Four words lost to FIFO_FULL, frame completed by padding.
    run_frame(32, 1, 1'b1, 1'b0);
    chk("overflow_set", 64'(OVERFLOW), 64'd1);

    // Random full pattern with pad stalls, plus a sync while awaiting WR_DONE.
    run_frame($urandom_range(4, 31), 2, 1'b1, 1'b1);

    // Master busy: sync is dropped, no start issued.
    WR_READY = 1'b0;
    sc0 = start_cnt;
    vsync_pulse(1'b0);
    exp_drop++;
    chk("no_start_not_ready", 64'(start_cnt), 64'(sc0));
    chk("drop_not_ready", 64'(DROP_CNT), 64'(exp_drop));
    WR_READY = 1'b1;

    run_frame(32, 0, 1'b0, 1'b0);
    chk("sticky_short", 64'(SHORT_FRAME), 64'd1);
    chk("sticky_overflow", 64'(OVERFLOW), 64'd1);

`ifdef DVP_TEST_PATTERN_EN
    TEST_MODE = 1'b1;
    run_frame(32, 0, 1'b0, 1'b0);
    chk("pattern_word0", got_q[0], 64'h0003_0002_0001_0000);
    TEST_MODE = 1'b0;
`endif

    ENABLE = 1'b0;
    cyc(3);
    chk("busy_disabled", 64'(BUSY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
